// File: rtl/norm_round_pipe_pkg.sv
// Shared types and defaults for the normalise/round pipeline.
package norm_pkg;

   localparam int unsigned FRAC_W_DEF = 23;
   localparam int unsigned EXP_W_DEF  = 8;
   localparam int unsigned GRS_W      = 3;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_POS = 2'b10,
      RM_NEG = 2'b11
   } round_mode_e;

   // Round-up decision from mode, sign, result lsb and {G,R,S}.
   function automatic logic round_inc(input round_mode_e mode,
                                      input logic sign,
                                      input logic lsb,
                                      input logic [GRS_W-1:0] grs);
      logic inexact;
      inexact = |grs;
      case (mode)
         RM_RNE:  round_inc = grs[2] & (grs[1] | grs[0] | lsb);
         RM_POS:  round_inc = ~sign & inexact;
         RM_NEG:  round_inc = sign & inexact;
         default: round_inc = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/norm_round_pipe_lzc.sv
// Leading-zero counter: count of zeros above the highest set bit.
module lzc #(
   parameter int unsigned W     = 27,
   parameter int unsigned CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     data_i,
   output logic [CNT_W-1:0] count_o,
   output logic             all_zero_o
);

   // Scan upward so the highest set bit wins; all-zero reports W.
   always_comb begin
      count_o    = CNT_W'(W);
      all_zero_o = 1'b1;
      for (int unsigned i = 0; i < W; i++) begin
         if (data_i[i]) begin
            count_o    = CNT_W'(W - 1 - i);
            all_zero_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/norm_round_pipe.sv
// Two-stage normalise (stage 1) and round/finalise (stage 2) pipeline
// with a valid/ready handshake on both sides.
module norm_round_pipe
   import norm_pkg::*;
#(
   parameter int unsigned FRAC_W = FRAC_W_DEF,
   parameter int unsigned EXP_W  = EXP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FRAC_W+4:0] in_mant,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic              in_sign,
   input  logic [1:0]        in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FRAC_W:0]   out_mant,
   output logic [EXP_W-1:0]  out_exp,
   output logic              out_sign,
   output logic              out_ovf,
   output logic              out_unf,
   output logic              out_zero
);

   localparam int unsigned MW    = FRAC_W + 5;       // carry + hidden + frac + GRS
   localparam int unsigned BW    = FRAC_W + 4;       // without carry
   localparam int unsigned CNT_W = $clog2(BW + 1);
   localparam int unsigned XW    = EXP_W + 2;        // room for sign and carry
   localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

   logic en1, en2;

   // Stage 1 registers
   logic              s1_valid_q;
   logic [FRAC_W:0]   s1_mant_q, s1_mant_d;
   logic [GRS_W-1:0]  s1_grs_q,  s1_grs_d;
   logic [EXP_W:0]    s1_exp_q,  s1_exp_d;
   logic              s1_sign_q;
   round_mode_e       s1_mode_q;
   logic              s1_zero_q, s1_zero_d;
   logic              s1_unf_q,  s1_unf_d;

   // Stage 2 (output) registers
   logic              out_valid_q;
   logic [FRAC_W:0]   out_mant_q, out_mant_d;
   logic [EXP_W-1:0]  out_exp_q,  out_exp_d;
   logic              out_sign_q;
   logic              out_ovf_q,  out_ovf_d;
   logic              out_unf_q,  out_unf_d;
   logic              out_zero_q, out_zero_d;

   logic [CNT_W-1:0]  lz_cnt;
   logic              lz_zero;
   logic [BW-1:0]     shifted;
   logic [XW-1:0]     diff;
   logic              inc;
   logic [FRAC_W+1:0] sum;
   logic [XW-1:0]     exp_r;

   assign en2       = ~out_valid_q | out_ready;
   assign en1       = ~s1_valid_q | en2;
   assign in_ready  = en1;
   assign out_valid = out_valid_q;
   assign out_mant  = out_mant_q;
   assign out_exp   = out_exp_q;
   assign out_sign  = out_sign_q;
   assign out_ovf   = out_ovf_q;
   assign out_unf   = out_unf_q;
   assign out_zero  = out_zero_q;

   lzc #(.W(BW), .CNT_W(CNT_W)) u_lzc (
      .data_i     (in_mant[BW-1:0]),
      .count_o    (lz_cnt),
      .all_zero_o (lz_zero)
   );

   // Stage 1: carry shift-right, or left-normalise with underflow flush.
   always_comb begin
      s1_mant_d = '0;
      s1_grs_d  = '0;
      s1_exp_d  = '0;
      s1_zero_d = 1'b0;
      s1_unf_d  = 1'b0;
      shifted   = in_mant[BW-1:0] << lz_cnt;
      diff      = {2'b00, in_exp} - XW'(lz_cnt);
      if (in_mant[MW-1]) begin
         s1_mant_d = in_mant[MW-1:GRS_W+1];
         s1_grs_d  = {in_mant[GRS_W], in_mant[2], in_mant[1] | in_mant[0]};
         s1_exp_d  = {1'b0, in_exp} + (EXP_W+1)'(1);
      end else if (lz_zero) begin
         s1_zero_d = 1'b1;
      end else if (diff[XW-1] || diff == '0) begin
         s1_zero_d = 1'b1;
         s1_unf_d  = 1'b1;
      end else begin
         s1_mant_d = shifted[BW-1:GRS_W];
         s1_grs_d  = shifted[GRS_W-1:0];
         s1_exp_d  = diff[EXP_W:0];
      end
   end

   // Stage 1 register: loads whenever stage 2 can drain it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mant_q  <= '0;
         s1_grs_q   <= '0;
         s1_exp_q   <= '0;
         s1_sign_q  <= 1'b0;
         s1_mode_q  <= RM_RNE;
         s1_zero_q  <= 1'b0;
         s1_unf_q   <= 1'b0;
      end else if (en1) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_mant_q <= s1_mant_d;
            s1_grs_q  <= s1_grs_d;
            s1_exp_q  <= s1_exp_d;
            s1_sign_q <= in_sign;
            s1_mode_q <= round_mode_e'(in_mode);
            s1_zero_q <= s1_zero_d;
            s1_unf_q  <= s1_unf_d;
         end
      end
   end

   // Stage 2: round, renormalise on carry-out, saturate on overflow.
   always_comb begin
      inc        = round_inc(s1_mode_q, s1_sign_q, s1_mant_q[0], s1_grs_q);
      sum        = {1'b0, s1_mant_q} + (FRAC_W+2)'(inc);
      exp_r      = {1'b0, s1_exp_q} + XW'(sum[FRAC_W+1]);
      out_mant_d = sum[FRAC_W+1] ? sum[FRAC_W+1:1] : sum[FRAC_W:0];
      out_exp_d  = exp_r[EXP_W-1:0];
      out_ovf_d  = 1'b0;
      out_unf_d  = 1'b0;
      out_zero_d = 1'b0;
      if (s1_zero_q) begin
         out_mant_d = '0;
         out_exp_d  = '0;
         out_zero_d = 1'b1;
         out_unf_d  = s1_unf_q;
      end else if (exp_r >= EXP_MAX) begin
         out_mant_d = '0;
         out_exp_d  = '1;
         out_ovf_d  = 1'b1;
      end
   end

   // Output register: holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_mant_q  <= '0;
         out_exp_q   <= '0;
         out_sign_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         out_unf_q   <= 1'b0;
         out_zero_q  <= 1'b0;
      end else if (en2) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_mant_q <= out_mant_d;
            out_exp_q  <= out_exp_d;
            out_sign_q <= s1_sign_q;
            out_ovf_q  <= out_ovf_d;
            out_unf_q  <= out_unf_d;
            out_zero_q <= out_zero_d;
         end
      end
   end

endmodule

// File: tb/tb_norm_round_pipe.sv
// Table-driven bench with a scoreboard for norm_round_pipe.
module tb_norm_round_pipe;

   localparam int FW = 23;
   localparam int EW = 8;

   typedef struct {
      logic [FW+4:0] mant;
      logic [EW-1:0] exp;
      logic          sign;
      logic [1:0]    mode;
      logic [FW:0]   e_mant;
      logic [EW-1:0] e_exp;
      logic          e_ovf;
      logic          e_unf;
      logic          e_zero;
   } vec_t;

   typedef struct {
      logic [35:0] want;
      int          acc_cyc;
      bit          chk_lat;
   } sb_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [FW+4:0] in_mant = '0;
   logic [EW-1:0] in_exp = '0;
   logic          in_sign = 1'b0;
   logic [1:0]    in_mode = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [FW:0]   out_mant;
   logic [EW-1:0] out_exp;
   logic          out_sign;
   logic          out_ovf, out_unf, out_zero;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   sb_t  sb[$];
   sb_t  cur;
   vec_t tbl[$];
   logic [35:0] held;
   bit   held_v = 1'b0;

   norm_round_pipe #(.FRAC_W(FW), .EXP_W(EW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mant   (in_mant),
      .in_exp    (in_exp),
      .in_sign   (in_sign),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mant  (out_mant),
      .out_exp   (out_exp),
      .out_sign  (out_sign),
      .out_ovf   (out_ovf),
      .out_unf   (out_unf),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic vec_t mk(input logic [FW+4:0] m, input logic [EW-1:0] e,
                               input logic s, input logic [1:0] md,
                               input logic [FW:0] em, input logic [EW-1:0] ee,
                               input logic o, input logic u, input logic z);
      vec_t v;
      v.mant = m; v.exp = e; v.sign = s; v.mode = md;
      v.e_mant = em; v.e_exp = ee; v.e_ovf = o; v.e_unf = u; v.e_zero = z;
      return v;
   endfunction

   function automatic logic [35:0] outvec();
      return {out_mant, out_exp, out_sign, out_ovf, out_unf, out_zero};
   endfunction

   // Monitor: pop/compare delivered beats, check stall stability, push accepted beats.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got %h, want no output", outvec());
         end else begin
            e = sb.pop_front();
            if (outvec() !== e.want) begin
               errors++;
               $display("FAIL beat_data: got %h, want %h", outvec(), e.want);
            end
            if (e.chk_lat) begin
               checks++;
               if (cyc - e.acc_cyc != 2) begin
                  errors++;
                  $display("FAIL latency: got %0d, want 2", cyc - e.acc_cyc);
               end
            end
         end
      end
      if (rst_n && out_valid && !out_ready) begin
         if (held_v) begin
            checks++;
            if (outvec() !== held) begin
               errors++;
               $display("FAIL stall_stable: got %h, want %h", outvec(), held);
            end
         end
         held   = outvec();
         held_v = 1'b1;
      end else begin
         held_v = 1'b0;
      end
      if (rst_n && in_valid && in_ready) begin
         e = cur;
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input vec_t v, input bit lat);
      int unsigned n;
      in_mant = v.mant; in_exp = v.exp; in_sign = v.sign; in_mode = v.mode;
      cur.want    = {v.e_mant, v.e_exp, v.sign, v.e_ovf, v.e_unf, v.e_zero};
      cur.chk_lat = lat;
      cur.acc_cyc = 0;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got in_ready=0, want 1 within 50 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end
   endtask

   task automatic expect1(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b, want %b", name, got, want);
      end
   endtask

   initial begin
      int unsigned stale;
      tbl.push_back(mk(28'h8000000, 8'd127, 0, 2'b00, 24'h800000, 8'd128, 0, 0, 0));
      tbl.push_back(mk(28'h0000008, 8'd127, 0, 2'b00, 24'h800000, 8'd104, 0, 0, 0));
      tbl.push_back(mk(28'h0000008, 8'd10,  0, 2'b00, 24'h000000, 8'd0,   0, 1, 1));
      tbl.push_back(mk(28'h400000C, 8'd127, 0, 2'b00, 24'h800002, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h400000C, 8'd127, 0, 2'b01, 24'h800001, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h400000C, 8'd127, 0, 2'b10, 24'h800002, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h400000C, 8'd127, 0, 2'b11, 24'h800001, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h400000C, 8'd127, 1, 2'b10, 24'h800001, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h400000C, 8'd127, 1, 2'b11, 24'h800002, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h7FFFFFC, 8'd127, 0, 2'b00, 24'h800000, 8'd128, 0, 0, 0));
      tbl.push_back(mk(28'h7FFFFFC, 8'd254, 0, 2'b00, 24'h000000, 8'hFF,  1, 0, 0));
      tbl.push_back(mk(28'h7FFFFFC, 8'd127, 0, 2'b01, 24'hFFFFFF, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h0000000, 8'd50,  1, 2'b00, 24'h000000, 8'd0,   0, 0, 1));
      tbl.push_back(mk(28'h4000004, 8'd127, 0, 2'b00, 24'h800000, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h4000006, 8'd127, 0, 2'b00, 24'h800001, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h4000001, 8'd127, 0, 2'b10, 24'h800001, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'h4000001, 8'd127, 0, 2'b11, 24'h800000, 8'd127, 0, 0, 0));
      tbl.push_back(mk(28'hC00000F, 8'd127, 1, 2'b00, 24'hC00001, 8'd128, 0, 0, 0));
      tbl.push_back(mk(28'h4000000, 8'd0,   0, 2'b00, 24'h000000, 8'd0,   0, 1, 1));
      tbl.push_back(mk(28'h4000000, 8'd1,   0, 2'b00, 24'h800000, 8'd1,   0, 0, 0));
      tbl.push_back(mk(28'h0000008, 8'd24,  0, 2'b00, 24'h800000, 8'd1,   0, 0, 0));
      tbl.push_back(mk(28'h0000008, 8'd23,  0, 2'b00, 24'h000000, 8'd0,   0, 1, 1));
      tbl.push_back(mk(28'h8000000, 8'd254, 0, 2'b00, 24'h000000, 8'hFF,  1, 0, 0));
      tbl.push_back(mk(28'h8000000, 8'd253, 0, 2'b00, 24'h800000, 8'd254, 0, 0, 0));

      // Reset state
      #3;
      checks++;
      if ({out_valid, outvec()} !== 37'd0) begin
         errors++;
         $display("FAIL reset_state: got %h, want 0", {out_valid, outvec()});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      expect1("ready_after_reset", in_ready, 1'b1);
      @(posedge clk); #1;

      // Table, back-to-back with latency checking
      out_ready = 1'b1;
      for (int i = 0; i < tbl.size(); i++) send(tbl[i], 1'b1);
      drain();

      // Stall: 4 beats, consumer held off
      out_ready = 1'b0;
      send(mk(28'h400000C, 8'd127, 0, 2'b00, 24'h800002, 8'd127, 0, 0, 0), 1'b0);
      send(mk(28'h0000008, 8'd127, 0, 2'b00, 24'h800000, 8'd104, 0, 0, 0), 1'b0);
      fork
         begin
            send(mk(28'h7FFFFFC, 8'd127, 0, 2'b00, 24'h800000, 8'd128, 0, 0, 0), 1'b0);
            send(mk(28'hC00000F, 8'd127, 1, 2'b00, 24'hC00001, 8'd128, 0, 0, 0), 1'b0);
         end
         begin
            @(negedge clk);
            expect1("stall_in_ready", in_ready, 1'b0);
            expect1("stall_out_valid", out_valid, 1'b1);
            repeat (2) @(negedge clk);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset with two beats in flight
      out_ready = 1'b0;
      send(mk(28'h8000000, 8'd100, 1, 2'b00, 24'h800000, 8'd101, 0, 0, 0), 1'b0);
      send(mk(28'h0000008, 8'd127, 0, 2'b00, 24'h800000, 8'd104, 0, 0, 0), 1'b0);
      expect1("inflight_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      expect1("async_clear_valid", out_valid, 1'b0);
      checks++;
      if (outvec() !== 36'd0) begin
         errors++;
         $display("FAIL async_clear_data: got %h, want 0", outvec());
      end
      sb.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      expect1("ready_after_release", in_ready, 1'b1);
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL stale_beat: got %0d valid cycles, want 0", stale);
      end
      @(posedge clk); #1;

      // Pipeline still works after reset
      send(mk(28'h400000C, 8'd127, 0, 2'b01, 24'h800001, 8'd127, 0, 0, 0), 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/norm_round_pipe.md
NORM_ROUND_PIPE -- requirements
Module: norm_round_pipe

Interface
REQ-001 SHALL have parameter FRAC_W, default 23, meaning stored fraction width.
REQ-002 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the beat this cycle.
REQ-007 SHALL have port in_mant, input, FRAC_W+5, packed as [FRAC_W+4] carry, [FRAC_W+3] hidden, fraction, then G, R, S in bits [2:0].
REQ-008 SHALL have port in_exp, input, EXP_W, unsigned biased exponent.
REQ-009 SHALL have port in_sign, input, 1; in_mode, input, 2, the rounding mode.
REQ-010 SHALL have port out_valid, output, 1; out_ready, input, 1.
REQ-011 SHALL have port out_mant, output, FRAC_W+1: hidden bit, then fraction; out_exp, output, EXP_W; out_sign, output, 1.
REQ-012 SHALL have port out_ovf, output, 1; out_unf, output, 1; out_zero, output, 1.

Function
REQ-013 Rounding modes SHALL be: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
REQ-014 The block SHALL be a 2-stage pipeline: stage 1 normalises, stage 2 rounds and finalises; latency 2 cycles from acceptance to out_valid; throughput one beat per cycle.
REQ-015 Handshake: en2 = !out_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1; a beat is accepted on in_valid & in_ready.
REQ-016 While out_valid & !out_ready, all out_* SHALL hold stable, and no beat SHALL be dropped, duplicated or reordered.
REQ-017 Stage 1, carry=1: shift right 1; new GRS = {shifted-out bit, G, R|S}; exp+1.
REQ-018 Stage 1, carry=0 with mantissa nonzero: count leading zeros from the hidden position (lzc); shift left by lzc with zero fill; exp-lzc.
REQ-019 Stage 1, in_mant zero: the result SHALL be exp 0, mantissa 0, out_zero=1, no rounding.
REQ-020 Stage 1 underflow: if exp-lzc <= 0 (signed compare, EXP_W+1 bits), the result SHALL flush to zero with out_unf=1 and out_zero=1.
REQ-021 Stage 2 rounding increment:
  - RNE: G & (R|S|lsb)
  - RTZ: 0
  - +inf: !sign & (G|R|S)
  - -inf: sign & (G|R|S)
REQ-022 Rounding carry-out (mantissa all ones + 1) SHALL give mantissa {1,0...}, exp+1.
REQ-023 Final exp >= 2^EXP_W-1 SHALL give out_exp all ones, out_mant 0, out_ovf=1.
REQ-024 out_sign SHALL equal the accepted in_sign; flags SHALL be mutually consistent: ovf and unf never both set.

Reset
REQ-025 rst_n low SHALL asynchronously clear s1_valid and out_valid, and zero all out_* data and flags.
REQ-026 Reset mid-operation SHALL discard in-flight beats; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-027 Package norm_pkg SHALL hold round_mode_e, GRS_W=3, and default FRAC_W/EXP_W.
REQ-028 Leading-zero counting SHALL be a sub-module lzc, parametrised on width, outputting count and all_zero.

Verification (FRAC_W=23, EXP_W=8, RNE unless stated)
REQ-029 in_mant 28'h8000000, exp 127 -> out_mant 24'h800000, exp 128, out_valid exactly 2 cycles after acceptance.
REQ-030 in_mant 28'h0000008, exp 127 -> out_mant 24'h800000, exp 104; same with exp 10 -> zero, out_unf=1.
REQ-031 in_mant 28'h400000C, exp 127 -> out_mant 24'h800002 in RNE; 24'h800001 in RTZ; 24'h800002 in +inf with sign 0; 24'h800001 in -inf with sign 0.
REQ-032 in_mant 28'h7FFFFFC, exp 127 -> out_mant 24'h800000, exp 128; same with exp 254 -> out_exp 8'hFF, mant 0, out_ovf=1.
REQ-033 Stream 4 beats with out_ready low for 3 cycles -> in_ready drops after 2 held beats, outputs stable while stalled, all 4 delivered in order.
REQ-034 Assert rst_n with 2 beats in flight -> out_valid is 0 immediately (asynchronous), no stale beat after release.
